dmem_responder: RTL and testbench

//  Memory-side responder for MEM-stage load/store requests. Accepts one

---
 rtl/riscv_pkg.sv | 50 +++++
 rtl/dmem_array.sv | 21 ++
 rtl/dmem_responder.sv | 129 ++++++++++++
 tb/tb_dmem_responder.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Memory-access size encoding and the byte/half lane helpers shared by the
// data-memory responder.
package riscv_pkg;

    localparam int DMEM_ADDR_WIDTH = 10;

    typedef enum logic [1:0] {
        MEM_B   = 2'b00,
        MEM_H   = 2'b01,
        MEM_W   = 2'b10,
        MEM_RSV = 2'b11
    } mem_size_t;

    // A request is rejected when it is not naturally aligned or uses the reserved size.
    function automatic logic access_error(input mem_size_t size, input logic [1:0] lane);
        case (size)
            MEM_B:   return 1'b0;
            MEM_H:   return lane[0];
            MEM_W:   return lane != 2'b00;
            default: return 1'b1;
        endcase
    endfunction

    function automatic logic [31:0] lane_extract(input logic [31:0] word,
                                                 input mem_size_t   size,
                                                 input logic [1:0]  lane);
        logic [31:0] shifted;
        shifted = word >> {lane, 3'b000};
        case (size)
            MEM_B:   return {24'd0, shifted[7:0]};
            MEM_H:   return {16'd0, shifted[15:0]};
            default: return word;
        endcase
    endfunction

    function automatic logic [31:0] lane_merge(input logic [31:0] word,
                                               input logic [31:0] wdata,
                                               input mem_size_t   size,
                                               input logic [1:0]  lane);
        logic [31:0] mask;
        case (size)
            MEM_B:   mask = 32'h0000_00FF;
            MEM_H:   mask = 32'h0000_FFFF;
            default: mask = 32'hFFFF_FFFF;
        endcase
        mask = mask << {lane, 3'b000};
        return (word & ~mask) | ((wdata << {lane, 3'b000}) & mask);
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Single-port word-wide data RAM with a registered one-cycle read.
module dmem_array #(
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic                  we,
    input  logic [31:0]           wdata,
    output logic [31:0]           rdata
);

    logic [31:0] mem [2**ADDR_WIDTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/dmem_responder.sv
// Memory-side responder for MEM-stage loads/stores: one request at a time,
// fixed access latency, sub-word stores done as read-modify-write.
module dmem_responder
    import riscv_pkg::*;
#(
    parameter int ADDR_WIDTH = DMEM_ADDR_WIDTH,
    parameter int LATENCY    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_we_i,
    input  logic [1:0]  req_size_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_rdata_o,
    output logic        rsp_err_o
);

    typedef enum logic [2:0] {IDLE, WAIT, READ, MERGE, RESP} state_t;

    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    state_t                state;
    state_t                state_next;
    logic [CW-1:0]         count;
    logic                  we;
    mem_size_t             size;
    logic [ADDR_WIDTH-1:0] index;
    logic [1:0]            lane;
    logic [31:0]           wdata;
    logic [31:0]           merged;
    logic [31:0]           rdata;
    logic                  err;
    logic                  accept;
    logic                  bad;
    logic                  count_done;
    logic                  word_store;
    logic                  ram_we;
    logic [31:0]           ram_wdata;
    logic [31:0]           ram_rdata;
    logic                  unused_addr;

    assign accept      = req_valid_i && req_ready_o;
    assign bad         = access_error(mem_size_t'(req_size_i), req_addr_i[1:0]);
    assign count_done  = (count == '0);
    assign word_store  = we && (size == MEM_W);
    // Bits above the word index alias onto the same array location.
    assign unused_addr = ^req_addr_i[31:ADDR_WIDTH+2];

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = bad ? RESP : WAIT;
            WAIT:    if (count_done) state_next = word_store ? RESP : READ;
            READ:    state_next = we ? MERGE : RESP;
            MERGE:   state_next = RESP;
            RESP:    if (rsp_ready_i) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        req_ready_o = (state == IDLE) && !rst;
        rsp_valid_o = (state == RESP);
        rsp_rdata_o = rdata;
        rsp_err_o   = err;
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            we    <= req_we_i;
            size  <= mem_size_t'(req_size_i);
            index <= req_addr_i[ADDR_WIDTH+1:2];
            lane  <= req_addr_i[1:0];
            wdata <= req_wdata_i;
        end
        if (state == READ && we) begin
            merged <= lane_merge(ram_rdata, wdata, size, lane);
        end
    end

    // Stores and rejected requests answer with zero data, so rdata is cleared on accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
            rdata <= '0;
            err   <= 1'b0;
        end else begin
            if (accept) begin
                count <= CW'(LATENCY - 1);
                rdata <= '0;
                err   <= bad;
            end
            if (state == WAIT && !count_done) begin
                count <= count - 1'b1;
            end
            if (state == READ && !we) begin
                rdata <= lane_extract(ram_rdata, size, lane);
            end
        end
    end

    // A write landing on the same edge as rst is suppressed.
    assign ram_we    = !rst && ((state == WAIT && count_done && word_store) || state == MERGE);
    assign ram_wdata = (state == MERGE) ? merged : wdata;

    dmem_array #(
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_array (
        .clk  (clk),
        .addr (index),
        .we   (ram_we),
        .wdata(ram_wdata),
        .rdata(ram_rdata)
    );

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: byte-level memory model, directed
// scenarios, then randomized traffic with response back-pressure.
module tb_dmem_responder;

    localparam int LAT = 2;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          acc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid_i;
    logic        req_ready_o;
    logic        req_we_i;
    logic [1:0]  req_size_i;
    logic [31:0] req_addr_i;
    logic [31:0] req_wdata_i;
    logic        rsp_valid_o;
    logic        rsp_ready_i;
    logic [31:0] rsp_rdata_o;
    logic        rsp_err_o;

    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    bit          bypass = 0;
    bit          bp_random = 0;
    int          hold_low = 0;
    bit          seen = 0;
    int          last_lat = 0;
    logic [31:0] last_rdata = '0;
    logic        last_err = 1'b0;
    logic [7:0]  bmem [4096];
    exp_t        exp_q [$];

    dmem_responder #(
        .ADDR_WIDTH(10),
        .LATENCY   (LAT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid_i(req_valid_i),
        .req_ready_o(req_ready_o),
        .req_we_i   (req_we_i),
        .req_size_i (req_size_i),
        .req_addr_i (req_addr_i),
        .req_wdata_i(req_wdata_i),
        .rsp_valid_o(rsp_valid_o),
        .rsp_ready_i(rsp_ready_i),
        .rsp_rdata_o(rsp_rdata_o),
        .rsp_err_o  (rsp_err_o)
    );

    initial forever #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Byte-addressed reference memory; ADDR_WIDTH=10 words means 4 KiB wraps.
    function automatic logic [31:0] model_peek(input logic [31:0] addr);
        int ba;
        ba = int'(addr[11:0]) & ~3;
        return {bmem[ba+3], bmem[ba+2], bmem[ba+1], bmem[ba]};
    endfunction

    task automatic model_step(input logic we, input logic [1:0] size, input logic [31:0] addr,
                              input logic [31:0] wdata, output exp_t e);
        int n;
        int ba;
        n       = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
        ba      = int'(addr[11:0]);
        e.rdata = '0;
        e.err   = (size == 2'd3) || (ba % n != 0);
        e.acc   = 0;
        if (e.err) begin
            e.lat = 1;
        end else if (we) begin
            for (int i = 0; i < n; i++) bmem[ba+i] = wdata[8*i +: 8];
            e.lat = (n == 4) ? LAT + 1 : LAT + 3;
        end else begin
            for (int i = 0; i < n; i++) e.rdata[8*i +: 8] = bmem[ba+i];
            e.lat = LAT + 2;
        end
    endtask

    task automatic issue_raw(input logic we, input logic [1:0] size, input logic [31:0] addr,
                             input logic [31:0] wdata, output bit ok);
        bit rdy;
        ok = 0;
        @(negedge clk);
        req_valid_i = 1'b1;
        req_we_i    = we;
        req_size_i  = size;
        req_addr_i  = addr;
        req_wdata_i = wdata;
        for (int n = 0; n < 300; n++) begin
            rdy = req_ready_o;
            @(posedge clk);
            #1;
            if (rdy) begin
                ok = 1;
                break;
            end
        end
        req_valid_i = 1'b0;
        if (!ok) begin
            checks++;
            errors++;
            $display("[TB] FAIL req_accept_timeout: got no accept expected accept within 300 cycles");
        end
    endtask

    task automatic applyStimulus(input logic we, input logic [1:0] size, input logic [31:0] addr,
                                 input logic [31:0] wdata);
        bit   ok;
        exp_t e;
        issue_raw(we, size, addr, wdata, ok);
        if (ok) begin
            model_step(we, size, addr, wdata, e);
            e.acc = cyc;
            exp_q.push_back(e);
        end
    endtask

    task automatic wait_idle();
        for (int n = 0; n < 400; n++) begin
            if (exp_q.size() == 0) break;
            @(negedge clk);
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL wait_idle: got %0d pending expected 0", exp_q.size());
            exp_q.delete();
        end
        @(negedge clk);
    endtask

    initial begin
        rsp_ready_i = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (hold_low > 0) begin
                rsp_ready_i = 1'b0;
                hold_low--;
            end else begin
                rsp_ready_i = bp_random ? ($urandom_range(0, 2) != 0) : 1'b1;
            end
        end
    end

    // Compare process: every response is checked against the head of the expectation queue.
    initial begin : compare_proc
        int   obs;
        exp_t e;
        forever begin
            @(negedge clk);
            if (cyc > 0 && !bypass) begin
                checkOutput("req_ready", 32'(req_ready_o), 32'(!rst && exp_q.size() == 0));
                if (rst || exp_q.size() == 0) begin
                    checkOutput("rsp_valid_idle", 32'(rsp_valid_o), 32'd0);
                    seen = 0;
                end else begin
                    e   = exp_q[0];
                    obs = cyc - e.acc + 1;
                    if (seen) checkOutput("rsp_valid_held", 32'(rsp_valid_o), 32'd1);
                    if (rsp_valid_o) begin
                        if (!seen) begin
                            checkOutput("rsp_latency", 32'(obs), 32'(e.lat));
                            last_lat = obs;
                            seen     = 1;
                        end
                        checkOutput("rsp_rdata", rsp_rdata_o, e.rdata);
                        checkOutput("rsp_err", 32'(rsp_err_o), 32'(e.err));
                        if (rsp_ready_i) begin
                            last_rdata = rsp_rdata_o;
                            last_err   = rsp_err_o;
                            void'(exp_q.pop_front());
                            seen = 0;
                        end
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] w0;
        logic [31:0] addr;
        logic [1:0]  sz;
        int          off;
        bit          ok;

        rst         = 1'b1;
        req_valid_i = 1'b0;
        req_we_i    = 1'b0;
        req_size_i  = 2'd0;
        req_addr_i  = '0;
        req_wdata_i = '0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("t1_reset_ready", 32'(req_ready_o), 32'd0);
        checkOutput("t1_reset_valid", 32'(rsp_valid_o), 32'd0);
        checkOutput("t1_reset_rdata", rsp_rdata_o, 32'd0);
        checkOutput("t1_reset_err", 32'(rsp_err_o), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checkOutput("t1_ready_after_reset", 32'(req_ready_o), 32'd1);

        for (int i = 0; i < 16; i++) applyStimulus(1'b1, 2'd2, 32'(i * 4), $urandom);
        wait_idle();

        applyStimulus(1'b1, 2'd2, 32'h10, 32'hDEADBEEF);
        wait_idle();
        checkOutput("t2_sw_latency", 32'(last_lat), 32'd3);
        applyStimulus(1'b0, 2'd2, 32'h10, 32'h0);
        wait_idle();
        checkOutput("t2_lw_rdata", last_rdata, 32'hDEADBEEF);
        checkOutput("t2_lw_err", 32'(last_err), 32'd0);
        checkOutput("t2_lw_latency", 32'(last_lat), 32'd4);

        applyStimulus(1'b1, 2'd2, 32'h10, 32'h11223344);
        applyStimulus(1'b1, 2'd0, 32'h13, 32'h000000AA);
        wait_idle();
        checkOutput("t3_sb_latency", 32'(last_lat), 32'd5);
        checkOutput("pin_model_word10", model_peek(32'h10), 32'hAA223344);
        applyStimulus(1'b0, 2'd2, 32'h10, 32'h0);
        wait_idle();
        checkOutput("t3_lw_merged", last_rdata, 32'hAA223344);
        applyStimulus(1'b0, 2'd0, 32'h12, 32'h0);
        wait_idle();
        checkOutput("t3_lb", last_rdata, 32'h00000022);
        applyStimulus(1'b0, 2'd1, 32'h12, 32'h0);
        wait_idle();
        checkOutput("t3_lh", last_rdata, 32'h0000AA22);

        applyStimulus(1'b0, 2'd2, 32'h06, 32'h0);
        wait_idle();
        checkOutput("t4_lw_mis_err", 32'(last_err), 32'd1);
        checkOutput("t4_lw_mis_rdata", last_rdata, 32'd0);
        checkOutput("t4_lw_mis_latency", 32'(last_lat), 32'd1);
        w0 = model_peek(32'h0);
        applyStimulus(1'b1, 2'd1, 32'h03, 32'hFFFF);
        wait_idle();
        checkOutput("t4_sh_mis_err", 32'(last_err), 32'd1);
        applyStimulus(1'b0, 2'd2, 32'h00, 32'h0);
        wait_idle();
        checkOutput("t4_word0_unchanged", last_rdata, w0);
        applyStimulus(1'b0, 2'd3, 32'h20, 32'h0);
        wait_idle();
        checkOutput("t4_rsv_err", 32'(last_err), 32'd1);

        hold_low = 12;
        applyStimulus(1'b0, 2'd2, 32'h10, 32'h0);
        applyStimulus(1'b1, 2'd2, 32'h14, 32'h12345678);
        wait_idle();
        checkOutput("pin_model_word14", model_peek(32'h14), 32'h12345678);

        bypass = 1;
        issue_raw(1'b1, 2'd0, 32'h13, 32'h00000055, ok);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        bypass = 0;
        repeat (4) @(negedge clk);
        applyStimulus(1'b0, 2'd2, 32'h10, 32'h0);
        wait_idle();
        checkOutput("t6_old_word", last_rdata, 32'hAA223344);
        applyStimulus(1'b0, 2'd2, 32'h1010, 32'h0);
        wait_idle();
        checkOutput("t6_alias", last_rdata, 32'hAA223344);

        bp_random = 1;
        for (int t = 0; t < 200; t++) begin
            sz  = ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            off = $urandom_range(0, 63);
            if ($urandom_range(0, 3) != 0) begin
                if (sz == 2'd1) off &= ~1;
                else if (sz == 2'd2) off &= ~3;
            end
            addr = ($urandom & 32'hFFFF_F000) | 32'(off);
            applyStimulus($urandom_range(0, 1) != 0, sz, addr, $urandom);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        wait_idle();
        bp_random = 0;
        repeat (3) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
